// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per clock, optional two's-complement
// operands, zero-operand fast path and valid/ready handshakes on both sides.
module seq_mult #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Magnitude of an operand; the most-negative value maps onto 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_sgn);
        logic [WIDTH-1:0] r;
        if (is_sgn && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [PW-1:0]      r_p;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_zero;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_sum;
    logic [PW-1:0]      w_acc_neg;
    logic               w_last;

    assign w_mag_a   = f_mag(a, sgn);
    assign w_mag_b   = f_mag(b, sgn);
    assign w_zero    = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
    // The multiplicand register is already shifted by the iteration count, so the low
    // multiplier bit selects whether this iteration's partial product is added.
    assign w_addend  = r_mplier[0] ? r_mcand : {PW{1'b0}};
    assign w_sum     = r_acc + w_addend;
    assign w_acc_neg = ~r_acc + {{(PW-1){1'b0}}, 1'b1};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= {PW{1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_acc       <= {PW{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_neg       <= 1'b0;
            r_p         <= {PW{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_zero) begin
                            r_p         <= {PW{1'b0}};
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                            r_mplier <= w_mag_b;
                            r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_acc    <= {PW{1'b0}};
                            r_cnt    <= {CNT_W{1'b0}};
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= {r_mcand[PW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_FIX: begin
                    r_p         <= r_neg ? w_acc_neg : r_acc;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: vector table plus random operands through a scoreboard queue, with
// hand-written backpressure, mid-run reset and WIDTH=4 sequences.
module tb_seq_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        sgn4;
    logic        out_valid4;
    logic        out_ready4;
    logic [7:0]  p4;
    logic        busy4;

    int n_cmp;
    int n_fail;
    logic [31:0] exp_q[$];
    logic [7:0]  exp4_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t tbl[10];

    seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sgn(sgn4), .out_valid(out_valid4), .out_ready(out_ready4),
        .p(p4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0] r;
        if (s) begin
            sx = {{16{x[15]}}, x};
            sy = {{16{y[15]}}, y};
            r  = sx * sy;
        end else begin
            r = {16'h0000, x} * {16'h0000, y};
        end
        return r;
    endfunction

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_b, input logic ts,
                         input logic [31:0] exp, input int hold);
        int n;
        int busy_n;
        int exp_lat;
        logic [31:0] e;
        exp_lat = (ta == 16'h0000 || tb_b == 16'h0000) ? 1 : 18;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a = ta; b = tb_b; sgn = ts; in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sgn = ~ts;
        n = 1;
        busy_n = 0;
        while (!out_valid && n < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("busy_cycles", 64'(busy_n), 64'(exp_lat - 1));
        chk("busy_low_in_done", {63'd0, busy}, 64'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("product", {32'd0, p}, {32'd0, e});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_p", {32'd0, p}, {32'd0, e});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed_out_valid", {63'd0, out_valid}, 64'd0);
        chk("consumed_in_ready", {63'd0, in_ready}, 64'd1);
        chk("p_retained", {32'd0, p}, {32'd0, e});
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_b, input logic ts,
                        input logic [7:0] exp);
        int n;
        logic [7:0] e;
        a4 = ta; b4 = tb_b; sgn4 = ts; in_valid4 = 1'b1;
        exp4_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 1;
        while (!out_valid4 && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("w4_latency", 64'(n), 64'd6);
        e = (exp4_q.size() > 0) ? exp4_q.pop_front() : 8'hDD;
        chk("w4_product", {56'd0, p4}, {56'd0, e});
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("w4_in_ready", {63'd0, in_ready4}, 64'd1);
    endtask

    initial begin
        int stray;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; sgn = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; sgn4 = 1'b0; out_ready4 = 1'b0;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 5};
        tbl[1] = '{16'h0003, 16'h0007, 1'b0, 32'h0000_0015, 0};
        tbl[2] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0};
        tbl[5] = '{16'h0000, 16'h1234, 1'b1, 32'h0000_0000, 0};
        tbl[6] = '{16'h1234, 16'h0000, 1'b0, 32'h0000_0000, 2};
        tbl[7] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 0};
        tbl[8] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, 0};
        tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_p", {32'd0, p}, 64'd0);
        chk("reset_p4", {56'd0, p4}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            run16(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, tbl[i].hold);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(1, 16'hFFFF));
            rb = 16'($urandom_range(1, 16'hFFFF));
            rs = 1'($urandom_range(0, 1));
            run16(ra, rb, rs, model16(ra, rb, rs), 0);
        end

        // Reset on the 8th RUN edge discards the operation.
        a = 16'h1234; b = 16'h5678; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_p", {32'd0, p}, 64'd0);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("midreset_stray", 64'(stray), 64'd0);
        run16(16'h0010, 16'h0010, 1'b0, 32'h0000_0100, 0);

        run4(4'h8, 4'h8, 1'b1, 8'h40);
        run4(4'hF, 4'hF, 1'b0, 8'hE1);
        run4(4'h8, 4'h1, 1'b1, 8'hF8);

        chk("scoreboard_empty", 64'(exp_q.size() + exp4_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised iterative shift-add multiplier. It is the sequential successor to the team's combinational 16x16 partial-product generator.
- Generates and accumulates one partial product per clock, so a WIDTH x WIDTH multiply costs one adder instead of WIDTH parallel rows.
- Adds a two's-complement signed mode, a zero-operand fast path, and valid/ready handshakes on input and output.
- Sits between the operand register file and the result writeback stage in the lab datapath.

Parameters:
- WIDTH, 16, operand width in bits (minimum 2); product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived from WIDTH, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b and sgn are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- sgn  input  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product.
- busy  output  1  high in RUN or FIX.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
  - rst has priority over all other activity and forces state IDLE in any state, including mid-RUN.
  - Reset values: in_ready=1, out_valid=0, busy=0, p=0, accumulator=0, counter=0. Any in-flight operation is discarded with no output.
- States: IDLE, RUN, FIX, DONE.
- Accept: a rising edge with in_valid=1 in IDLE is the accept edge.
  - a, b and sgn are sampled only at this edge; later changes are ignored.
- Signed preparation at accept:
  - If sgn=1, latch magnitudes |a| and |b| as WIDTH-bit unsigned, plus neg = a[MSB] XOR b[MSB].
  - The most-negative value maps to magnitude 2^(WIDTH-1); this fits, so no saturation.
  - If sgn=0, magnitudes are the raw operands and neg=0.
- Zero fast path: if a==0 or b==0 at the accept edge, go IDLE->DONE directly.
  - p=0 and out_valid=1 after that single edge. neg is ignored, so the result is never negative zero.
- RUN: accumulator cleared at the accept edge, counter=0. Each RUN edge:
  - If multiplier bit [counter] = 1, add (multiplicand << counter) zero-extended to 2*WIDTH bits into the accumulator.
  - Counter increments.
  - After WIDTH RUN edges (counter reaches WIDTH), go to FIX.
  - No carry out of 2*WIDTH bits is possible.
- FIX (one edge): p <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits; go to DONE.
- Latency (normal path): out_valid is first high after the (WIDTH+2)th rising edge, counting the accept edge as the first.
  - Edge 1 accepts, edges 2..WIDTH+1 are RUN, edge WIDTH+2 is FIX->DONE.
  - Latency is fixed and independent of operand values, except for the zero fast path.
- DONE:
  - out_valid=1, in_ready=0, busy=0; p stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - A new operand cannot be accepted in that same cycle; at most one operation is in flight.
- p retains its last value after consumption and changes only on entry to DONE or on reset.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
- Unsigned 0xFFFF x 0xFFFF (WIDTH=16) -> p=0xFFFE0001.
  - out_valid rises after the 18th edge from accept; busy high for 17 cycles.
- Signed: 0xFFFD x 0x0005 -> p=0xFFFFFFF1. Signed 0x8000 x 0x0001 -> 0xFFFF8000. Signed 0x8000 x 0x8000 -> 0x40000000.
- Zero fast path: a=0x0000, b=0x1234, sgn=1 -> p=0, out_valid one edge after accept, busy never asserted.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid: p and out_valid are stable, in_ready=0.
  - Then raise out_ready: IDLE next edge.
  - A second operand pair 0x0003 x 0x0007 (unsigned) presented immediately -> 0x00000015 at the correct latency.
- Reset mid-operation: assert rst on the 8th RUN edge -> next cycle IDLE, in_ready=1, out_valid=0, p=0, no stray result. A following 0x0010 x 0x0010 -> 0x00000100.
- Parametrisation: WIDTH=4, signed 0x8 x 0x8 -> 0x40; unsigned 0xF x 0xF -> 0xE1; latency 6 edges.
